spi_target_bridge: RTL and testbench
====================================

// Module: spi_target_bridge
// PURPOSE
//  SPI mode-0 target (slave) that lets an external SPI host act as a bus initiator on the SoC
//  valid/ready memory bus: host frames become 32-bit word reads/writes on mem_*.
//  Used for debug/bring-up access into SDRAM/IO space.
//  SPI pins are oversampled in the clk domain; clk must be >= 8x spi_sclk.
// PARAMETERS
//  SYNC_STAGES  2             synchronizer depth on spi_sclk/spi_cs_n/spi_mosi (>=2)
//  FILL_WORD    32'hFFFF_FFFF read data returned when bus read not complete in time
// PORTS
//  clk          in   1   system clock, single clock domain
//  rst          in   1   asynchronous reset, active-high
//  spi_sclk     in   1   SPI clock from host, idle low (CPOL=0, CPHA=0)
//  spi_cs_n     in   1   chip select from host, active-low, frames a transaction
//  spi_mosi     in   1   host->target data, MSB first
//  spi_miso     out  1   target->host data, MSB first
//  spi_miso_oe  out  1   MISO output enable; high only while synchronized cs_n is low
//  mem_valid    out  1   bus request; held until mem_ready
//  mem_ready    in   1   bus completion, one-cycle pulse
//  mem_addr     out  32  word address, [1:0] forced 0
//  mem_wdata    out  32  write data
//  mem_wstrb    out  4   4'hF for write, 4'h0 for read
//  mem_rdata    in   32  read data, valid when mem_ready
//  busy         out  1   high from frame start until IDLE re-entered
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; shift regs, bit/byte counters, sticky LATE cleared.
//  Sampling: MOSI captured on synchronized sclk rising edge; MISO updated on falling edge;
//   first MISO bit of a byte presented at falling edge ending the previous byte.
//  Frame: CS low -> cmd byte, then per-command bytes, all MSB first:
//   0x02 WRITE: 4 addr bytes, 4 data bytes -> bus write.
//   0x03 READ : 4 addr bytes -> bus read issued immediately; 1 dummy byte; 4 data bytes out.
//   0x05 STAT : 1 byte out = {LATE, 6'b0, PEND}; PEND = mem_valid; read clears LATE.
//   other     : DROP (MOSI ignored, MISO=0) until CS high.
//  States: IDLE, CMD, ADDR, WDATA, WBUS, RBUS_DUMMY, RDATA, STAT, DROP.
//   IDLE->CMD on CS falling; CMD->ADDR/STAT/DROP after 8 bits; ADDR->WDATA|RBUS_DUMMY
//   after 32 bits; WDATA->WBUS after 32 bits (mem_valid=1 next cycle);
//   RBUS_DUMMY->RDATA after 8 dummy bits; any->IDLE on CS rising except as below.
//  Bus handshake: mem_valid rises one clk after last address/data bit; addr/wdata/wstrb stable
//   while valid; valid drops the cycle after mem_ready seen. Never withdrawn except by rst.
//  Read timing: at end of dummy byte, if rdata captured -> shift it out; else shift FILL_WORD,
//   set LATE; the outstanding bus read still completes, result discarded.
//  CS rising mid-frame: before last WDATA bit -> no bus op; during WBUS/pending read ->
//   mem_valid held until mem_ready, then IDLE (busy stays high until then).
//  CS falling while a bus op is pending -> frame is DROP; MISO=0 for whole frame.
//  Extra SCLKs after the defined length: MOSI ignored, MISO=0, no further bus ops.
//  Bit counter is 3 bits and wraps per byte; byte counter saturates at final byte.
//  Async rst mid-operation: immediate return to reset values, including mem_valid=0.
// TESTING
//  WRITE 02 10000000 00000041, ready after 2 clk -> one request: addr 0x10000000,
//   wdata 0x41, wstrb F; valid high exactly until ready.
//  READ 03 20000004 + dummy + 4 bytes, ready after 3 clk with rdata 0xCAFEF00D ->
//   MISO returns CA FE F0 0D; STAT then returns 0x00.
//  READ with mem_ready delayed past dummy byte -> MISO FF FF FF FF; STAT returns 0x80 then
//   0x00 on second STAT; valid drops one clk after late ready.
//  WRITE with CS raised after 2 data bytes -> mem_valid never asserted; next STAT = 0x00.
//  CS raised during WBUS with ready stalled 20 clk -> valid held 20 clk, busy low after.
//  rst asserted while mem_valid=1 -> mem_valid, spi_miso_oe, busy 0 same cycle; cmd 0x7E -> DROP.

Source files
------------

// File: rtl/spi_target_bridge.sv
// SPI mode-0 target bridging host frames onto the valid/ready memory bus.
// SPI pins are oversampled and synchronized into the clk domain.
module spi_target_bridge #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] FILL_WORD   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WBUS,
    S_RBUS_DUMMY, S_RDATA, S_STAT, S_DROP
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_s;
  logic [SYNC_STAGES-1:0] r_cs_s;
  logic [SYNC_STAGES-1:0] r_mosi_s;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [1:0]  r_byte_cnt;
  logic [30:0] r_sr_in;
  logic [31:0] r_sr_out;
  logic        r_miso;
  logic        r_is_write;
  logic        r_late;
  logic        r_rd_done;
  logic [31:0] r_rdata;
  logic        r_mem_valid;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  logic        w_sclk;
  logic        w_cs_n;
  logic        w_mosi;
  logic        w_rise;
  logic        w_fall;
  logic        w_cs_fall;
  logic        w_byte_done;
  logic [31:0] w_word;
  logic        w_ack;
  logic        w_rd_ok;
  logic [31:0] w_rd_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_s <= '0;
      r_cs_s   <= '1;
      r_mosi_s <= '0;
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b1;
    end else begin
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], spi_sclk};
      r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_d <= w_sclk;
      r_cs_d   <= w_cs_n;
    end
  end

  assign w_sclk      = r_sclk_s[SYNC_STAGES-1];
  assign w_cs_n      = r_cs_s[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_s[SYNC_STAGES-1];
  assign w_rise      = w_sclk & ~r_sclk_d & ~w_cs_n;
  assign w_fall      = ~w_sclk & r_sclk_d & ~w_cs_n;
  assign w_cs_fall   = ~w_cs_n & r_cs_d;
  assign w_byte_done = w_rise & (r_bit_cnt == 3'd7);
  assign w_word      = {r_sr_in, w_mosi};
  assign w_ack       = r_mem_valid & mem_ready;
  assign w_rd_ok     = w_ack | r_rd_done;
  assign w_rd_word   = w_ack ? mem_rdata : r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_byte_cnt  <= 2'd0;
      r_sr_in     <= '0;
      r_sr_out    <= '0;
      r_miso      <= 1'b0;
      r_is_write  <= 1'b0;
      r_late      <= 1'b0;
      r_rd_done   <= 1'b0;
      r_rdata     <= '0;
      r_mem_valid <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= 4'h0;
    end else begin
      if (w_ack) begin
        r_mem_valid <= 1'b0;
        if (r_wstrb == 4'h0) begin
          r_rdata   <= mem_rdata;
          r_rd_done <= 1'b1;
        end
      end
      if (w_rise) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_sr_in   <= w_word[30:0];
      end
      if (w_fall) begin
        if (r_state == S_DROP) begin
          r_miso <= 1'b0;
        end else begin
          r_miso   <= r_sr_out[31];
          r_sr_out <= {r_sr_out[30:0], 1'b0};
        end
      end
      if (w_byte_done && r_byte_cnt != 2'd3)
        r_byte_cnt <= r_byte_cnt + 2'd1;

      if (r_state == S_IDLE) begin
        if (w_cs_fall) begin
          r_bit_cnt  <= 3'd0;
          r_byte_cnt <= 2'd0;
          r_sr_out   <= '0;
          r_miso     <= 1'b0;
          r_rd_done  <= 1'b0;
          r_state    <= r_mem_valid ? S_DROP : S_CMD;
        end
      end else if (w_cs_n && !r_mem_valid) begin
        r_state <= S_IDLE;
      end else if (w_cs_fall) begin
        // new frame while the previous bus op is still outstanding
        r_bit_cnt <= 3'd0;
        r_sr_out  <= '0;
        r_miso    <= 1'b0;
        r_state   <= S_DROP;
      end else if (w_byte_done) begin
        unique case (r_state)
          S_CMD: begin
            r_byte_cnt <= 2'd0;
            unique case (w_word[7:0])
              8'h02: begin
                r_is_write <= 1'b1;
                r_state    <= S_ADDR;
              end
              8'h03: begin
                r_is_write <= 1'b0;
                r_state    <= S_ADDR;
              end
              8'h05: begin
                r_sr_out <= {r_late, 6'b0, r_mem_valid, 24'h0};
                r_late   <= 1'b0;
                r_state  <= S_STAT;
              end
              default: r_state <= S_DROP;
            endcase
          end
          S_ADDR: begin
            if (r_byte_cnt == 2'd3) begin
              r_addr     <= {w_word[31:2], 2'b00};
              r_byte_cnt <= 2'd0;
              if (r_is_write) begin
                r_state <= S_WDATA;
              end else begin
                r_wstrb     <= 4'h0;
                r_mem_valid <= 1'b1;
                r_state     <= S_RBUS_DUMMY;
              end
            end
          end
          S_WDATA: begin
            if (r_byte_cnt == 2'd3) begin
              r_wdata     <= w_word;
              r_wstrb     <= 4'hF;
              r_mem_valid <= 1'b1;
              r_state     <= S_WBUS;
            end
          end
          S_RBUS_DUMMY: begin
            r_byte_cnt <= 2'd0;
            r_state    <= S_RDATA;
            if (w_rd_ok) begin
              r_sr_out <= w_rd_word;
            end else begin
              r_sr_out <= FILL_WORD;
              r_late   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = ~w_cs_n;
  assign mem_valid   = r_mem_valid;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign mem_wstrb   = r_wstrb;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_target_bridge.sv
// Directed bench for spi_target_bridge: SPI host model plus a
// memory responder with programmable ready latency.
module tb_spi_target_bridge;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  int          ready_delay = 2;
  logic [31:0] rd_val = 32'h0;
  int          cnt = 0;
  int          req_count = 0;
  int          last_vhigh = 0;
  int          unstable = 0;
  logic        ready_prev = 1'b0;
  logic        post_ready_valid = 1'b1;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  logic [3:0]  last_wstrb = 4'h0;

  spi_target_bridge #(
    .SYNC_STAGES(2),
    .FILL_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // memory responder: ready pulses after ready_delay cycles of valid
  always @(negedge clk) begin
    if (rst) begin
      cnt        = 0;
      mem_ready  = 1'b0;
      ready_prev = 1'b0;
    end else begin
      if (ready_prev) post_ready_valid = mem_valid;
      ready_prev = 1'b0;
      mem_ready  = 1'b0;
      mem_rdata  = 32'h0;
      if (mem_valid) begin
        cnt++;
        if (cnt == 1) begin
          req_count++;
          last_addr  = mem_addr;
          last_wdata = mem_wdata;
          last_wstrb = mem_wstrb;
        end else if (mem_addr !== last_addr || mem_wdata !== last_wdata ||
                     mem_wstrb !== last_wstrb) begin
          unstable++;
        end
        if (cnt == ready_delay) begin
          mem_ready  = 1'b1;
          mem_rdata  = rd_val;
          last_vhigh = cnt;
          cnt        = 0;
          ready_prev = 1'b1;
        end
      end
    end
  end

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      #(HALF);
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      #(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_word(input logic [31:0] tx, output logic [31:0] rx);
    logic [7:0] b;
    for (int i = 3; i >= 0; i--) begin
      spi_byte(tx[i*8 +: 8], b);
      rx[i*8 +: 8] = b;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic cs_high();
    #(HALF);
    spi_cs_n = 1'b1;
    #(2*HALF);
  endtask

  task automatic do_stat(output logic [7:0] st);
    logic [7:0] d;
    cs_low();
    spi_byte(8'h05, d);
    spi_byte(8'h00, st);
    cs_high();
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle busy=%b want 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({mem_valid, busy, spi_miso, spi_miso_oe} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctl got %b want 0000",
               {mem_valid, busy, spi_miso, spi_miso_oe});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin
      n_err++;
      $display("FAIL reset_bus got %h %h %h want 0", mem_addr, mem_wdata, mem_wstrb);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0]  b;
    logic [31:0] w;
    int          r0;
    r0 = req_count;
    ready_delay = 2;
    post_ready_valid = 1'b1;
    cs_low();
    spi_byte(8'h02, b);
    spi_word(32'h1000_0000, w);
    spi_word(32'h0000_0041, w);
    cs_high();
    wait_idle("write");
    n_cmp++;
    if (req_count - r0 != 1) begin
      n_err++;
      $display("FAIL write_reqs got %0d want 1", req_count - r0);
    end
    n_cmp++;
    if ({last_addr, last_wdata, last_wstrb} !== {32'h1000_0000, 32'h41, 4'hF}) begin
      n_err++;
      $display("FAIL write_bus got %h %h %h want 10000000 00000041 f",
               last_addr, last_wdata, last_wstrb);
    end
    n_cmp++;
    if (last_vhigh != 2 || post_ready_valid !== 1'b0 || unstable != 0) begin
      n_err++;
      $display("FAIL write_hs got vhigh=%0d post=%b unst=%0d want 2 0 0",
               last_vhigh, post_ready_valid, unstable);
    end
  endtask

  task automatic test_read();
    logic [7:0]  b;
    logic [31:0] w;
    ready_delay = 3;
    rd_val = 32'hCAFE_F00D;
    cs_low();
    spi_byte(8'h03, b);
    spi_word(32'h2000_0004, w);
    spi_byte(8'h00, b);
    spi_word(32'h0, w);
    cs_high();
    wait_idle("read");
    n_cmp++;
    if (w !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL read_data got %h want cafef00d", w);
    end
    n_cmp++;
    if (last_addr !== 32'h2000_0004 || last_wstrb !== 4'h0) begin
      n_err++;
      $display("FAIL read_bus got %h %h want 20000004 0", last_addr, last_wstrb);
    end
    do_stat(b);
    n_cmp++;
    if (b !== 8'h00) begin
      n_err++;
      $display("FAIL read_stat got %h want 00", b);
    end
  endtask

  task automatic test_read_late();
    logic [7:0]  b;
    logic [31:0] w;
    ready_delay = 200;
    rd_val = 32'h1234_5678;
    post_ready_valid = 1'b1;
    cs_low();
    spi_byte(8'h03, b);
    spi_word(32'h2000_0008, w);
    spi_byte(8'h00, b);
    spi_word(32'h0, w);
    cs_high();
    wait_idle("late");
    n_cmp++;
    if (w !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL late_data got %h want ffffffff", w);
    end
    n_cmp++;
    if (last_vhigh != 200 || post_ready_valid !== 1'b0) begin
      n_err++;
      $display("FAIL late_hs got vhigh=%0d post=%b want 200 0",
               last_vhigh, post_ready_valid);
    end
    do_stat(b);
    n_cmp++;
    if (b !== 8'h80) begin
      n_err++;
      $display("FAIL late_stat1 got %h want 80", b);
    end
    do_stat(b);
    n_cmp++;
    if (b !== 8'h00) begin
      n_err++;
      $display("FAIL late_stat2 got %h want 00", b);
    end
  endtask

  task automatic test_write_abort();
    logic [7:0]  b;
    logic [31:0] w;
    int          r0;
    r0 = req_count;
    ready_delay = 2;
    cs_low();
    spi_byte(8'h02, b);
    spi_word(32'h3000_0000, w);
    spi_byte(8'h11, b);
    spi_byte(8'h22, b);
    cs_high();
    repeat (20) @(negedge clk);
    wait_idle("abort");
    n_cmp++;
    if (req_count != r0 || mem_valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_reqs got %0d valid=%b want %0d 0",
               req_count, mem_valid, r0);
    end
    do_stat(b);
    n_cmp++;
    if (b !== 8'h00) begin
      n_err++;
      $display("FAIL abort_stat got %h want 00", b);
    end
  endtask

  task automatic test_wbus_stall();
    logic [7:0]  b;
    logic [31:0] w;
    ready_delay = 20;
    cs_low();
    spi_byte(8'h02, b);
    spi_word(32'h0000_0100, w);
    spi_word(32'h1234_5678, w);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({mem_valid, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL stall_hold got valid=%b busy=%b want 1 1", mem_valid, busy);
    end
    wait_idle("stall");
    n_cmp++;
    if (last_vhigh != 20 || last_wdata !== 32'h1234_5678 || last_addr !== 32'h100) begin
      n_err++;
      $display("FAIL stall_bus got vhigh=%0d %h %h want 20 12345678 00000100",
               last_vhigh, last_wdata, last_addr);
    end
    #(2*HALF);
  endtask

  task automatic test_reset_mid_op();
    logic [7:0]  b;
    logic [31:0] w;
    int          r0;
    ready_delay = 1000;
    cs_low();
    spi_byte(8'h02, b);
    spi_word(32'h0000_0200, w);
    spi_word(32'hAABB_CCDD, w);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (mem_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rstop_pre got valid=%b want 1", mem_valid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({mem_valid, spi_miso_oe, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL rstop_clear got %b want 000", {mem_valid, spi_miso_oe, busy});
    end
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    ready_delay = 2;
    repeat (4) @(negedge clk);
    r0 = req_count;
    cs_low();
    spi_byte(8'h7E, b);
    spi_byte(8'hA5, b);
    n_cmp++;
    if (b !== 8'h00 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL drop_b1 got %h busy=%b want 00 1", b, busy);
    end
    spi_byte(8'hFF, b);
    n_cmp++;
    if (b !== 8'h00) begin
      n_err++;
      $display("FAIL drop_b2 got %h want 00", b);
    end
    cs_high();
    wait_idle("drop");
    n_cmp++;
    if (req_count != r0) begin
      n_err++;
      $display("FAIL drop_reqs got %0d want %0d", req_count, r0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_late();
    test_write_abort();
    test_wbus_stall();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
